// File: rtl/mic_rx_pkg.sv
// Shared register map, bit positions and receiver state encoding for the I2S microphone receiver.
package mic_rx_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int unsigned ST_LEVEL_W   = 5;
    localparam int unsigned ST_OVERFLOW  = 8;
    localparam int unsigned ST_FRAME_ERR = 9;
    localparam int unsigned ST_EMPTY     = 10;
    localparam int unsigned ST_FULL      = 11;

    localparam int unsigned CTL_ENABLE = 0;
    localparam int unsigned CTL_FLUSH  = 1;
    localparam int unsigned CTL_IRQ_EN = 2;

    localparam int unsigned DATA_VALID    = 31;
    localparam int unsigned DATA_CHANNEL  = 30;
    localparam int unsigned DATA_SAMPLE_W = 30;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_DONE  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/mic_rx_fifo.sv
// Single-clock show-ahead FIFO with level output and one-cycle flush.
module mic_rx_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full, empty, do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop_i && !empty && !flush_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: synchronises the I2S pins, deserialises words into a FIFO
// and exposes DATA/STATUS/CONTROL registers over Avalon-MM.
module i2s_mic_rx #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mic_bclk,
    input  logic        mic_lrclk,
    input  logic        mic_sd,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        irq
);
    import mic_rx_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        bclk_sync_q, lr_sync_q, sd_sync_q;
    logic              bclk_prev_q, lr_prev_q;
    logic              tick, ws_edge, lr_s, sd_s;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] shifted;
    logic              push_c, frame_err_set_c;

    logic              enable_q, irq_en_q, overflow_q, frame_err_q, irq_q;
    logic [31:0]       readdata_q;
    logic              readdatavalid_q;

    logic [DATA_W:0]   fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty, fifo_full, pop_c, ctl_wr_c, flush_c, ovf_set_c;
    logic [31:0]       rd_mux_c;
    logic              unused_wdata;

    // Pin synchronisers; the WS history only advances on bclk rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], mic_bclk};
            lr_sync_q   <= {lr_sync_q[0], mic_lrclk};
            sd_sync_q   <= {sd_sync_q[0], mic_sd};
            bclk_prev_q <= bclk_sync_q[1];
            if (tick) lr_prev_q <= lr_sync_q[1];
        end
    end

    assign lr_s    = lr_sync_q[1];
    assign sd_s    = sd_sync_q[1];
    assign tick    = bclk_sync_q[1] && !bclk_prev_q;
    assign ws_edge = tick && (lr_s != lr_prev_q);
    assign shifted = {shift_q, sd_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            chan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            chan_q  <= chan_d;
        end
    end

    // The WS-edge tick is not shifted, giving the I2S one-bit delay.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shift_d         = shift_q;
        chan_d          = chan_q;
        push_c          = 1'b0;
        frame_err_set_c = 1'b0;
        if (!enable_q) begin
            state_d = RX_IDLE;
        end else if (ws_edge) begin
            frame_err_set_c = (state_q == RX_SHIFT);
            cnt_d           = '0;
            chan_d          = lr_s;
            state_d         = RX_SHIFT;
        end else if (tick && state_q == RX_SHIFT) begin
            shift_d = shifted[DATA_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                push_c  = 1'b1;
                state_d = RX_DONE;
            end
        end
    end

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop_c      = avs_read && (avs_address == ADDR_DATA) && !fifo_empty;
    assign ctl_wr_c   = avs_write && (avs_address == ADDR_CONTROL);
    assign flush_c    = ctl_wr_c && avs_writedata[CTL_FLUSH];
    assign ovf_set_c  = push_c && fifo_full && !pop_c && !flush_c;
    assign unused_wdata = ^avs_writedata[31:3];

    mic_rx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_c),
        .push_i      (push_c),
        .push_data_i ({chan_q, shifted}),
        .pop_i       (pop_c),
        .head_o      (fifo_head),
        .level_o     (fifo_level)
    );

    always_comb begin
        rd_mux_c = '0;
        case (avs_address)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    rd_mux_c[DATA_VALID]          = 1'b1;
                    rd_mux_c[DATA_CHANNEL]        = fifo_head[DATA_W];
                    rd_mux_c[DATA_SAMPLE_W-1:0]   = DATA_SAMPLE_W'($signed(fifo_head[DATA_W-1:0]));
                end
            end
            ADDR_STATUS: begin
                rd_mux_c[ST_LEVEL_W-1:0] = ST_LEVEL_W'(fifo_level);
                rd_mux_c[ST_OVERFLOW]    = overflow_q;
                rd_mux_c[ST_FRAME_ERR]   = frame_err_q;
                rd_mux_c[ST_EMPTY]       = fifo_empty;
                rd_mux_c[ST_FULL]        = fifo_full;
            end
            ADDR_CONTROL: begin
                rd_mux_c[CTL_ENABLE] = enable_q;
                rd_mux_c[CTL_IRQ_EN] = irq_en_q;
            end
            default: rd_mux_c = '0;
        endcase
    end

    // Control, sticky flags and the registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q        <= 1'b0;
            irq_en_q        <= 1'b0;
            overflow_q      <= 1'b0;
            frame_err_q     <= 1'b0;
            irq_q           <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            if (ctl_wr_c) begin
                enable_q <= avs_writedata[CTL_ENABLE];
                irq_en_q <= avs_writedata[CTL_IRQ_EN];
            end
            if (flush_c) begin
                overflow_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end else begin
                overflow_q  <= overflow_q || ovf_set_c;
                frame_err_q <= frame_err_q || frame_err_set_c;
            end
            irq_q           <= irq_en_q && !fifo_empty;
            readdatavalid_q <= avs_read;
            if (avs_read) readdata_q <= rd_mux_c;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Self-checking bench for i2s_mic_rx: drives I2S frames and Avalon accesses against a word-level model.
module tb_i2s_mic_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        mic_bclk, mic_lrclk, mic_sd;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_readdatavalid, irq;

    always #5 clk = ~clk;

    i2s_mic_rx #(.DATA_W(24), .FIFO_DEPTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .mic_bclk          (mic_bclk),
        .mic_lrclk         (mic_lrclk),
        .mic_sd            (mic_sd),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    // Word-level model: FIFO contents as {channel, sample}, sticky flags, control state.
    logic [24:0] exp_q[$];
    bit          ovf_m, ferr_m, en_m, irq_en_m, short_m;
    logic        lr_cur = 1'b0;
    bit          b2b_rd = 1'b0;
    logic [31:0] b2b_data;

    function automatic logic [31:0] fmt(input logic [24:0] e);
        logic [31:0] r;
        r = {1'b1, e[24], {6{e[23]}}, e[23:0]};
        return r;
    endfunction

    function automatic logic [31:0] status_m();
        logic [31:0] r;
        logic [4:0]  lvl;
        lvl = 5'(exp_q.size());
        r = {20'b0, exp_q.size() == 16, exp_q.size() == 0, ferr_m, ovf_m, 3'b0, lvl};
        return r;
    endfunction

    task automatic model_push(input logic [24:0] e);
        if (exp_q.size() == 16) ovf_m = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        ovf_m = 0; ferr_m = 0; en_m = 0; irq_en_m = 0; short_m = 0;
    endtask

    // One bit clock period: data set while bclk low, optional DATA read aligned to the capture cycle.
    task automatic tick(input logic lr, input logic sd);
        mic_lrclk = lr;
        mic_sd    = sd;
        lr_cur    = lr;
        repeat (5) @(negedge clk);
        mic_bclk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b2b_rd && i == 1) begin
                avs_address = 2'd0;
                avs_read    = 1'b1;
            end
            if (b2b_rd && i == 2) begin
                avs_read = 1'b0;
                b2b_data = avs_readdata;
            end
        end
        mic_bclk = 1'b0;
    endtask

    // Frame on the opposite channel: WS tick, nbits MSB-first data bits, then pad idle bits.
    task automatic send_frame(input logic [23:0] w, input int nbits, input int pad, input bit last_rd);
        logic ch;
        ch = ~lr_cur;
        if (en_m && short_m) ferr_m = 1'b1;
        tick(ch, 1'($urandom));
        for (int i = 0; i < nbits; i++) begin
            b2b_rd = last_rd && (i == nbits - 1);
            tick(ch, w[23 - i]);
            b2b_rd = 1'b0;
        end
        for (int i = 0; i < pad; i++) tick(ch, 1'($urandom));
        if (en_m) begin
            if (nbits >= 24) begin
                model_push({ch, w});
                short_m = 0;
            end else begin
                short_m = 1;
            end
        end
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d, output logic v);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
        v = avs_readdatavalid;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        if (a == 2'd2) begin
            en_m     = d[0];
            irq_en_m = d[2];
            if (d[1]) begin
                exp_q.delete();
                ovf_m  = 0;
                ferr_m = 0;
            end
            if (!en_m) short_m = 0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (avs_readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata got %h exp %h", avs_readdata, 32'h0); end
        n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", avs_readdatavalid); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL reset_status got %h exp %h", d, status_m()); end
        avs_rd(2'd2, d, v);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_control got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_left_word();
        logic [31:0] d;
        logic        v;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        avs_wr(2'd2, 32'h1);
        send_frame(24'hA5A5A5, 24, 2, 1'b0);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL left_status got %h exp %h", d, status_m()); end
        avs_rd(2'd0, d, v);
        void'(exp_q.pop_front());
        n_cmp++; if (d !== 32'hBFA5A5A5) begin n_err++; $display("FAIL left_data got %h exp %h", d, 32'hBFA5A5A5); end
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL left_level0 got %h exp %h", d, status_m()); end
    endtask

    task automatic test_right_word();
        logic [31:0] d;
        logic        v;
        send_frame(24'h012345, 24, 2, 1'b0);
        avs_rd(2'd0, d, v);
        void'(exp_q.pop_front());
        n_cmp++; if (d !== 32'hC0012345) begin n_err++; $display("FAIL right_data got %h exp %h", d, 32'hC0012345); end
    endtask

    task automatic test_short_frame();
        logic [31:0] d, e;
        logic        v;
        send_frame(24'($urandom), 10, 0, 1'b0);
        send_frame(24'($urandom), 24, 2, 1'b0);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL short_status got %h exp %h", d, status_m()); end
        e = fmt(exp_q.pop_front());
        avs_rd(2'd0, d, v);
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL short_next_word got %h exp %h", d, e); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic        v;
        for (int k = 0; k < 17; k++) send_frame(24'($urandom), 24, 1, 1'b0);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL ovf_status got %h exp %h", d, status_m()); end
        for (int k = 0; k < 16; k++) begin
            e = fmt(exp_q.pop_front());
            avs_rd(2'd0, d, v);
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL ovf_read%0d got %h exp %h", k, d, e); end
        end
    endtask

    task automatic test_empty_flush();
        logic [31:0] d;
        logic        v;
        avs_rd(2'd0, d, v);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL empty_read got %h exp %h", d, 32'h0); end
        n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL empty_read_valid got %b exp 1", v); end
        @(negedge clk);
        n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL valid_single_pulse got %b exp 0", avs_readdatavalid); end
        for (int k = 0; k < 5; k++) send_frame(24'($urandom), 24, 1, 1'b0);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL pre_flush_status got %h exp %h", d, status_m()); end
        avs_wr(2'd2, 32'h3);
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL post_flush_status got %h exp %h", d, status_m()); end
        avs_rd(2'd2, d, v);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL control_readback got %h exp %h", d, 32'h1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        logic        v;
        for (int k = 0; k < 16; k++) send_frame(24'($urandom), 24, 1, 1'b0);
        e = fmt(exp_q.pop_front());
        send_frame(24'($urandom), 24, 2, 1'b1);
        n_cmp++; if (b2b_data !== e) begin n_err++; $display("FAIL b2b_pop got %h exp %h", b2b_data, e); end
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL b2b_status got %h exp %h", d, status_m()); end
        avs_wr(2'd2, 32'h3);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        avs_wr(2'd2, 32'h5);
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL irq_empty got %b exp 0", irq); end
        send_frame(24'($urandom), 24, 2, 1'b0);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL irq_nonempty got %b exp 1", irq); end
        avs_wr(2'd2, 32'h1);
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL irq_disabled got %b exp 0", irq); end
        avs_wr(2'd2, 32'h5);
        avs_rd(2'd0, d, v);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL irq_drained got %b exp 0", irq); end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] d, e;
        logic        v;
        logic        ch;
        send_frame(24'($urandom), 24, 2, 1'b0);
        avs_rd(2'd1, d, v);
        ch = ~lr_cur;
        for (int k = 0; k < 13; k++) tick(ch, 1'($urandom));
        avs_address = 2'd1;
        avs_read    = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b exp 0", avs_readdatavalid); end
        n_cmp++; if (avs_readdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_readdata got %h exp %h", avs_readdata, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_mid_irq got %b exp 0", irq); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_post_valid got %b exp 0", avs_readdatavalid); end
        avs_rd(2'd1, d, v);
        n_cmp++; if (d !== status_m()) begin n_err++; $display("FAIL rst_post_status got %h exp %h", d, status_m()); end
        tick(lr_cur, 1'b0);
        tick(lr_cur, 1'b0);
        avs_wr(2'd2, 32'h5);
        send_frame(24'($urandom), 24, 2, 1'b0);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL rst_irq_after got %b exp 1", irq); end
        e = fmt(exp_q.pop_front());
        avs_rd(2'd0, d, v);
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rst_first_capture got %h exp %h", d, e); end
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== (irq_en_m && exp_q.size() > 0)) begin n_err++; $display("FAIL rst_irq_empty got %b exp 0", irq); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        mic_bclk      = 1'b0;
        mic_lrclk     = 1'b0;
        mic_sd        = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_left_word();
        test_right_word();
        test_short_frame();
        test_overflow();
        test_empty_flush();
        test_back_to_back();
        test_irq();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
